// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter control path: frame FSM states,
// TX output mux select codes, and the default payload width.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Select codes understood by the downstream TX output mux.
  localparam logic [1:0] MUX_IDLE  = 2'd0;  // line high (idle and stop bit)
  localparam logic [1:0] MUX_START = 2'd1;  // line low (start bit)
  localparam logic [1:0] MUX_DATA  = 2'd2;  // ser_data
  localparam logic [1:0] MUX_PAR   = 2'd3;  // par_bit

  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// The payload is loaded on accept. ser_data is a registered output, so it
// holds its value outside the data phase instead of following the counter.
// One bit is presented per cycle, LSB first. done flags the last data bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  shift,
  output logic                  ser_data,
  output logic                  done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic                  advance;

  // The next bit is pre-fetched during START and every data cycle except the
  // last one. ser_data therefore shows bit[cnt] during each data cycle.
  assign advance = start | (shift & ~done);
  assign done    = shift && (cnt == CW'(DATA_WIDTH - 1));

  // Shift register, counter and output bit. Load and advance never coincide.
  // NOTE: state registers use non-blocking assignments and an async reset branch
  // only. Blocking here would create simulation races against other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      ser_data <= 1'b0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else begin
      if (advance) begin
        ser_data <= sreg[0];
        sreg     <= sreg >> 1;
      end
      if (shift) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control stage. It accepts a parallel payload, runs the
// idle/start/data/parity/stop frame FSM, and drives the TX mux select, the
// serial data bit and the parity bit. The block sends one frame bit per clock.
// The optional macro UART_TX_BACK2BACK_EN lets STOP accept the next payload
// directly, so frames go out back to back with no IDLE cycle between them.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   par_en_q;
  logic   last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk       (CLK),
    .rst       (RST),
    .load      (accept),
    .load_data (P_DATA),
    .start     (state == START),
    .shift     (state == DATA),
    .ser_data  (ser_data),
    .done      (last_bit)
  );

  // Frame state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the accept strobe for payload/config capture.
  // NOTE: every always_comb output gets a default first. A missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (DATA_VALID) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START:  state_nxt = DATA;
      DATA:   if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: state_nxt = STOP;
      STOP: begin
`ifdef UART_TX_BACK2BACK_EN
        if (DATA_VALID) begin
          accept    = 1'b1;
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the parity enable and precompute the parity bit on accept. The
  // parity bit is then stable for the whole frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else if (accept) begin
      par_en_q <= PAR_EN;
      par_bit  <= (^P_DATA) ^ PAR_TYP;
    end
  end

  // Mux select is decoded from the registered state, so reset forces the
  // line high immediately.
  always_comb begin
    mux_sel = MUX_IDLE;
    case (state)
      START:   mux_sel = MUX_START;
      DATA:    mux_sel = MUX_DATA;
      PARITY:  mux_sel = MUX_PAR;
      default: mux_sel = MUX_IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Upstream control stage of the UART transmitter.
- Accepts a parallel byte with a valid strobe and runs the frame FSM (idle/start/data/parity/stop).
- Serializes the data LSB-first and computes the parity bit.
- Drives the 2-bit select, serial data and parity bit consumed by the TX output mux.
- One frame bit per CLK cycle; baud-rate gating is done outside this block.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal range 5..9).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel payload
DATA_VALID  input  1  payload strobe; sampled only when accepted (see Behaviour)
PAR_EN  input  1  1 = insert parity bit; sampled with payload
PAR_TYP  input  1  0 = even, 1 = odd; sampled with payload
mux_sel  output  2  0 = idle/stop (line high), 1 = start (line low), 2 = ser_data, 3 = par_bit
ser_data  output  1  current data bit
par_bit  output  1  parity of latched payload
busy  output  1  frame in progress

Behaviour:
- Reset (async assert, sync release): state=IDLE; mux_sel=0, ser_data=0, par_bit=0, busy=0; shift register, bit counter and latched config cleared.
- States: IDLE, START, DATA, PARITY, STOP. mux_sel is decoded from the registered state: IDLE/STOP=0, START=1, DATA=2, PARITY=3.
- IDLE: if DATA_VALID=1 at a rising edge, latch P_DATA, PAR_EN and PAR_TYP, then go to START. busy goes high in the same cycle as START. DATA_VALID low keeps the FSM in IDLE.
- START: one cycle, then DATA. Bit counter is 0 on entry.
- DATA: exactly DATA_WIDTH cycles. ser_data = bit[cnt] of the latched data, LSB first. The counter increments every cycle. After the last bit, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one cycle. par_bit = XOR-reduce(latched data) XOR latched PAR_TYP. par_bit is valid from START onward and held until the next accept.
- STOP: one cycle, then IDLE. busy drops with IDLE.
- Frame length: 2 + DATA_WIDTH + PAR_EN cycles. Accept-to-next-accept minimum is that length + 1, for the IDLE cycle.
- DATA_VALID while busy=1: ignored, no queuing. P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect.
- ser_data outside DATA is don't-care to the mux, but is held at its last value (no toggling).
- Reset mid-frame: immediate return to IDLE with reset output values. The line goes high (mux_sel=0) asynchronously.
- DATA_VALID asserted in the same cycle RST releases: not accepted.

Optional Feature:
- Macro: UART_TX_BACK2BACK_EN.
- Defined: in STOP, DATA_VALID=1 latches new payload/config and transitions directly to START. busy stays high and there is no IDLE cycle, so throughput is one frame per 2 + DATA_WIDTH + PAR_EN cycles.
- Undefined: STOP always returns to IDLE and DATA_VALID in STOP is ignored.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - mux_sel constants MUX_IDLE=2'd0, MUX_START=2'd1, MUX_DATA=2'd2, MUX_PAR=2'd3, shared with the TX mux;
  - the default DATA_WIDTH.
- One sub-module, uart_tx_serializer: load-enable data register, bit counter (clog2(DATA_WIDTH) bits), ser_data output, and a done flag at the last bit. The FSM and parity logic stay in uart_tx_ctrl.

Test Plan:
- Reset then idle: RST pulse, DATA_VALID=0 for 20 cycles -> mux_sel=0, busy=0 throughout.
- Even-parity frame: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulse -> mux_sel 1,2×8,3,0 over 11 cycles; ser_data 1,0,1,0,0,1,0,1; par_bit=0; busy high for 11 cycles.
- Odd parity, no-parity variant: 0xA5 with PAR_TYP=1 -> par_bit=1. 0x3C with PAR_EN=0 -> 10-cycle frame, no mux_sel=3, ser_data 0,0,1,1,1,1,0,0.
- Busy rejection: DATA_VALID held high with P_DATA changing every cycle during a 0x5A frame -> transmitted bits match 0x5A. Next accept occurs only after one IDLE cycle (macro undefined).
- Reset mid-frame: assert RST on data bit 3 -> mux_sel=0 and busy=0 immediately; next frame 0xFF transmits correctly.
- Back-to-back (UART_TX_BACK2BACK_EN): DATA_VALID held high with 0x01 then 0x80, PAR_EN=0 -> two 10-cycle frames contiguous, STOP followed directly by START, busy never drops.
